// File: rtl/prescaled_updown_counter.sv
// Up/down counter with clock-enable prescaler, load, modulus and terminal count.
// Define COUNTER_SATURATE_EN to saturate at the bounds instead of wrapping.
module prescaled_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int PRESCALE  = 10000000,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE-1);
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RSTV  = WIDTH'(RESET_VAL);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] ld_v;
  logic             at_top;
  logic             at_bot;

  always_ff @(posedge clk) begin
    if (rst)
      pre_cnt <= '0;
    else if (en)
      pre_cnt <= (pre_cnt == PLAST) ? '0 : pre_cnt + 1'b1;
  end

  assign tick = !rst && en && (pre_cnt == PLAST);

  // out-of-range values behave as the top of the range
  assign cur    = (count > MAXV) ? MAXV : count;
  assign at_top = (cur == MAXV);
  assign at_bot = (cur == '0);
  assign tc     = tick && !load && (updown ? at_top : at_bot);
  assign ld_v   = (load_val > MAXV) ? MAXV : load_val;

  always_comb begin
    step = cur;
    if (updown) begin
      if (at_top) begin
`ifdef COUNTER_SATURATE_EN
        step = MAXV;
`else
        step = '0;
`endif
      end else begin
        step = cur + 1'b1;
      end
    end else begin
      if (at_bot) begin
`ifdef COUNTER_SATURATE_EN
        step = '0;
`else
        step = MAXV;
`endif
      end else begin
        step = cur - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= RSTV;
    else if (load)
      count <= ld_v;
    else if (tick)
      count <= step;
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench for prescaled_updown_counter (WIDTH=4, PRESCALE=4, MAX=9).
// Expected count/tick/tc per cycle are hand-computed in the row calls.
module tb_prescaled_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       updown;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tick;
  logic       tc;

  typedef struct {
    logic [3:0] c;
    logic       t;
    logic       tc;
    int         id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rid    = 0;

  prescaled_updown_counter #(
    .WIDTH(4), .PRESCALE(4), .MAX_VAL(9), .RESET_VAL(9)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .updown(updown),
    .load(load), .load_val(load_val),
    .count(count), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic row(input int n, input bit r, input bit e,
                     input bit u, input bit l, input int lv,
                     input int c, input bit t, input bit tcx);
    exp_t x;
    rid++;
    repeat (n) begin
      @(posedge clk);
      #1;
      rst      = r;
      en       = e;
      updown   = u;
      load     = l;
      load_val = 4'(lv);
      x.c  = 4'(c);
      x.t  = t;
      x.tc = tcx;
      x.id = rid;
      q.push_back(x);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (count !== x.c || tick !== x.t || tc !== x.tc) begin
          errors++;
          $display("FAIL row%0d count/tick/tc got %0d/%b/%b want %0d/%b/%b",
                   x.id, count, tick, tc, x.c, x.t, x.tc);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; en = 1'b0; updown = 1'b1; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
`ifdef COUNTER_SATURATE_EN
    row(1, 1, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 1, 8,  9, 0, 0);
    row(2, 0, 1, 1, 0, 0,  8, 0, 0);
    row(1, 0, 1, 1, 0, 0,  8, 1, 0);
    row(3, 0, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 0, 0,  9, 1, 1);
    row(3, 0, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 0, 0,  9, 1, 1);
    row(3, 0, 1, 0, 0, 0,  9, 0, 0);
    row(1, 0, 1, 0, 0, 0,  9, 1, 0);
    row(1, 0, 1, 0, 0, 0,  8, 0, 0);
`else
    // reset, then count up through the wrap
    row(1, 1, 1, 1, 0, 0,  9, 0, 0);
    row(3, 0, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 0, 0,  9, 1, 1);
    row(3, 0, 1, 1, 0, 0,  0, 0, 0);
    row(1, 0, 1, 1, 0, 0,  0, 1, 0);
    row(3, 0, 1, 1, 0, 0,  1, 0, 0);
    row(1, 0, 1, 1, 0, 0,  1, 1, 0);
    row(3, 0, 1, 1, 0, 0,  2, 0, 0);
    row(1, 0, 1, 1, 0, 0,  2, 1, 0);
    // count down through zero
    row(3, 0, 1, 0, 0, 0,  3, 0, 0);
    row(1, 0, 1, 0, 0, 0,  3, 1, 0);
    row(3, 0, 1, 0, 0, 0,  2, 0, 0);
    row(1, 0, 1, 0, 0, 0,  2, 1, 0);
    row(3, 0, 1, 0, 0, 0,  1, 0, 0);
    row(1, 0, 1, 0, 0, 0,  1, 1, 0);
    row(3, 0, 1, 1, 0, 0,  0, 0, 0);
    row(1, 0, 1, 0, 0, 0,  0, 1, 1);
    row(3, 0, 1, 0, 0, 0,  9, 0, 0);
    row(1, 0, 1, 0, 0, 0,  9, 1, 0);
    row(3, 0, 1, 0, 0, 0,  8, 0, 0);
    row(1, 0, 1, 0, 0, 0,  8, 1, 0);
    // enable gaps stretch the period
    row(2, 0, 1, 0, 0, 0,  7, 0, 0);
    row(3, 0, 0, 0, 0, 0,  7, 0, 0);
    row(1, 0, 1, 0, 0, 0,  7, 0, 0);
    row(1, 0, 1, 0, 0, 0,  7, 1, 0);
    row(3, 0, 1, 0, 0, 0,  6, 0, 0);
    row(2, 0, 0, 0, 0, 0,  6, 0, 0);
    row(1, 0, 1, 0, 0, 0,  6, 1, 0);
    // reset on a tick cycle
    row(3, 0, 1, 0, 0, 0,  5, 0, 0);
    row(1, 1, 1, 0, 0, 0,  5, 0, 0);
    row(3, 0, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 0, 0,  9, 1, 1);
    // loads: clamp, override tick and tc, independent of en
    row(3, 0, 1, 1, 0, 0,  0, 0, 0);
    row(1, 0, 1, 1, 1, 12, 0, 1, 0);
    row(3, 0, 1, 1, 0, 0,  9, 0, 0);
    row(1, 0, 1, 1, 1, 5,  9, 1, 0);
    row(3, 0, 1, 1, 0, 0,  5, 0, 0);
    row(1, 0, 1, 1, 0, 0,  5, 1, 0);
    row(1, 0, 0, 1, 1, 3,  6, 0, 0);
    row(1, 0, 0, 1, 0, 0,  3, 0, 0);
    row(3, 0, 1, 1, 0, 0,  3, 0, 0);
    row(1, 0, 1, 1, 0, 0,  3, 1, 0);
    row(1, 0, 1, 1, 0, 0,  4, 0, 0);
`endif
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
# prescaled_updown_counter

Parametrised up/down counter with an integrated clock-enable prescaler, synchronous load, programmable modulus and terminal-count output. It replaces the divided-clock LED counter pattern: the whole block runs on the single board clock `clk`, and the prescaler produces a one-cycle `tick` enable instead of a derived clock. It drives LED banks and 7-segment digit counters, and can be cascaded through `tc`.

## Interface
- `WIDTH`, 4: counter width in bits.
- `PRESCALE`, 10000000: `clk` cycles per count step. Must be >= 1.
- `MAX_VAL`, 2**WIDTH-1: highest count value. The count runs modulo `MAX_VAL+1`. Must be <= 2**WIDTH-1.
- `RESET_VAL`, 2**WIDTH-1: count value after reset. Must be <= `MAX_VAL`.

Reset is `rst`: synchronous, active-high. The clock is `clk`.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  prescaler/count enable. When 0, all state holds.
- `updown`  in  1  1 = count up, 0 = count down. Sampled on tick cycles.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `count`  out  WIDTH  registered counter value.
- `tick`  out  1  one-cycle step enable (combinational).
- `tc`  out  1  terminal-count pulse (combinational).

## Operation
- Prescaler `pre_cnt` has width max(1, clog2(PRESCALE)).
  - `rst` sets it to 0.
  - When `en`=1, it increments each cycle and wraps from `PRESCALE-1` to 0.
  - When `en`=0, it holds.
- `tick` = `!rst && en && pre_cnt==PRESCALE-1`. With `PRESCALE`=1, `tick`=`en`.
- `count` update priority, evaluated at each rising edge:
  1. `rst`: `count`<=`RESET_VAL`.
  2. `load`: `count`<=min(`load_val`, `MAX_VAL`). This happens regardless of `en` or `tick`, and the prescaler is not disturbed.
  3. `tick` && `updown`: if `count`==`MAX_VAL`, `count`<=0; otherwise `count`+1.
  4. `tick` && !`updown`: if `count`==0, `count`<=`MAX_VAL`; otherwise `count`-1.
  5. In all other cases, `count` holds.
- `tc` = `tick && !load && (updown ? count==MAX_VAL : count==0)`. It is asserted in the cycle before the wrap edge, which lets a downstream stage use `tc` as its `en`.
- Any out-of-range `count` value (possible only through a bad parameter) is treated as `MAX_VAL` on the next tick.
- A direction change takes effect on the next tick only. There is no glitch step.

## Timing
- Reset values: `count`=`RESET_VAL`, `pre_cnt`=0, `tick`=0, `tc`=0 while `rst`=1.
- After `rst` deasserts with `en`=1 held, the first `tick` arrives in the `PRESCALE`th cycle, so the first `count` change is visible `PRESCALE` cycles after reset release.
- Step period is exactly `PRESCALE` enabled cycles. Cycles with `en`=0 stretch the period and do not reset `pre_cnt`.
- Load latency is 1 cycle: `load_val` is visible on `count` after the next edge.
- `load` and `tick` in the same cycle: load wins, the step is lost, `tc`=0, and the prescaler still wraps.
- `rst` mid-operation: everything returns to its reset value on that edge, including a pending load or tick.
- No multicycle paths. `tick` and `tc` are combinational from registers and inputs (`en`, `updown`, `load`, `rst`).

## Configuration
- `COUNTER_SATURATE_EN` defined: the counter saturates instead of wrapping.
  - Up at `MAX_VAL` holds `MAX_VAL`.
  - Down at 0 holds 0.
  - `tc` still pulses on every tick while at the boundary in the current direction.
- `COUNTER_SATURATE_EN` undefined: modulo wrap as described in Operation. This is the default.

## Test plan
All scenarios use `WIDTH`=4, `PRESCALE`=4, `MAX_VAL`=9, `RESET_VAL`=9 unless stated.

- Reset, then `en`=1, `updown`=1 -> `count`=9; `tc`=1 with the first tick (cycle 4); `count`=0 after that edge; then `count` 1, 2, 3 every 4 cycles.
- `updown`=0 from `count`=0 -> `tc` pulses on that tick; `count` becomes 9, then 8, 7.
- `en` toggled 0 for 3 cycles mid-period -> tick is delayed by exactly 3 cycles; `count` never steps while `en`=0.
- `load`=1, `load_val`=12 on a tick cycle -> `count`=9 (clamped) next cycle; no step; `tc`=0; next tick occurs 4 cycles later.
- `rst` asserted on a tick cycle while `count`=5 -> `count`=9, `tick`=0 and `pre_cnt`=0 after the edge; the first step comes 4 cycles after release.
- `COUNTER_SATURATE_EN` defined, up from 8 -> `count` goes to 9 and stays 9 on all later ticks; `tc`=1 on each of those ticks.
